// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave
// Description : SPI slave, modes 0-3, single i_Clk domain. SCK, CS_n and MOSI
//               are brought in through 2-flop synchronizers. Edges of the
//               synchronized SCK drive a byte-wide RX shifter and a TX shifter
//               that is fed from a one-byte holding register.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_Clk          in   system clock, rising edge
//   i_Rst          in   synchronous active-high reset
//   i_TX_Byte      in   [7:0] byte to return to the master on MISO
//   i_TX_DV        in   one-cycle strobe, i_TX_Byte valid
//   o_TX_Ready     out  holding register empty
//   o_RX_DV        out  one-cycle pulse, o_RX_Byte holds a new byte
//   o_RX_Byte      out  [7:0] last complete byte received on MOSI
//   i_SPI_Clk      in   SPI clock (asynchronous)
//   i_SPI_CS_n     in   chip select, active low (asynchronous)
//   i_SPI_MOSI     in   serial data from master (asynchronous)
//   o_SPI_MISO     out  serial data to master, MSB first
//   o_SPI_MISO_En  out  tristate enable for MISO
// ============================================================================
module spi_slave #(
    parameter int SPI_MODE = 0
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_SPI_MISO_En
);

    localparam logic c_CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic c_CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Synchronizers plus one extra stage for edge detection
    logic       r_sck_meta_q,  r_sck_sync_q,  r_sck_prev_q;
    logic       r_cs_meta_q,   r_cs_sync_q,   r_cs_prev_q;
    logic       r_mosi_meta_q, r_mosi_sync_q;
    // Post-reset CS qualification
    logic [1:0] r_flush_cnt_q, w_flush_cnt_d;
    logic       r_cs_armed_q,  w_cs_armed_d;
    // Protocol state
    state_t     r_state_q,     w_state_d;
    logic [2:0] r_bit_cnt_q,   w_bit_cnt_d;
    logic [6:0] r_rx_shift_q,  w_rx_shift_d;
    logic [7:0] r_rx_byte_q,   w_rx_byte_d;
    logic       r_rx_dv_q,     w_rx_dv_d;
    logic [7:0] r_tx_hold_q,   w_tx_hold_d;
    logic       r_tx_ready_q,  w_tx_ready_d;
    logic [7:0] r_tx_shift_q,  w_tx_shift_d;
    logic       r_miso_q,      w_miso_d;
    logic       r_miso_en_q,   w_miso_en_d;

    logic       w_active;
    logic       w_sck_lead;
    logic       w_sck_trail;
    logic       w_sample;
    logic       w_shift;
    logic       w_cs_fall;
    logic       w_cs_rise;
    logic       w_byte_done;
    logic       w_byte_load;
    logic [7:0] w_load_val;
    logic       w_tx_accept;

    assign w_active    = (r_state_q == ST_ACTIVE);
    assign w_sck_lead  = (r_sck_prev_q == c_CPOL) && (r_sck_sync_q != c_CPOL);
    assign w_sck_trail = (r_sck_prev_q != c_CPOL) && (r_sck_sync_q == c_CPOL);
    assign w_sample    = w_active && (c_CPHA ? w_sck_trail : w_sck_lead);
    assign w_shift     = w_active && (c_CPHA ? w_sck_lead : w_sck_trail);
    // A falling CS_n only counts once CS_n has been seen high after reset, so
    // a transfer that was in flight when reset hit is not restarted midway.
    assign w_cs_fall   = r_cs_armed_q && r_cs_prev_q && !r_cs_sync_q;
    assign w_cs_rise   = !r_cs_prev_q && r_cs_sync_q;
    assign w_byte_done = w_sample && (r_bit_cnt_q == 3'd7) && !w_cs_rise;
    assign w_byte_load = (!w_active && w_cs_fall) || w_byte_done;
    // Underrun (holding empty) sends 0x00
    assign w_load_val  = r_tx_ready_q ? 8'h00 : r_tx_hold_q;
    assign w_tx_accept = i_TX_DV && r_tx_ready_q;

    always_comb begin
        w_flush_cnt_d = r_flush_cnt_q;
        w_cs_armed_d  = r_cs_armed_q;
        w_state_d     = r_state_q;
        w_bit_cnt_d   = r_bit_cnt_q;
        w_rx_shift_d  = r_rx_shift_q;
        w_rx_byte_d   = r_rx_byte_q;
        w_rx_dv_d     = 1'b0;
        w_tx_hold_d   = r_tx_hold_q;
        w_tx_ready_d  = r_tx_ready_q;
        w_tx_shift_d  = r_tx_shift_q;
        w_miso_d      = r_miso_q;
        w_miso_en_d   = r_miso_en_q;

        // The synchronizer chain holds reset values for two cycles; CS_n is
        // trusted only after that.
        if (r_flush_cnt_q != 2'd2) begin
            w_flush_cnt_d = r_flush_cnt_q + 2'd1;
        end
        if ((r_flush_cnt_q == 2'd2) && r_cs_sync_q) begin
            w_cs_armed_d = 1'b1;
        end

        // Holding register handshake; accept and empty never coincide since
        // accept needs the register already empty.
        if (w_tx_accept) begin
            w_tx_hold_d  = i_TX_Byte;
            w_tx_ready_d = 1'b0;
        end
        if (w_byte_load && !r_tx_ready_q) begin
            w_tx_ready_d = 1'b1;
        end

        case (r_state_q)
            ST_IDLE: begin
                w_miso_d     = 1'b0;
                w_miso_en_d  = 1'b0;
                w_bit_cnt_d  = 3'd0;
                w_rx_shift_d = 7'd0;
                w_tx_shift_d = 8'h00;
                if (w_cs_fall) begin
                    w_state_d   = ST_ACTIVE;
                    w_miso_en_d = 1'b1;
                    if (c_CPHA) begin
                        w_tx_shift_d = w_load_val;
                    end else begin
                        w_miso_d     = w_load_val[7];
                        w_tx_shift_d = {w_load_val[6:0], 1'b0};
                    end
                end
            end
            default: begin
                if (w_cs_rise) begin
                    w_state_d    = ST_IDLE;
                    w_miso_d     = 1'b0;
                    w_miso_en_d  = 1'b0;
                    w_bit_cnt_d  = 3'd0;
                    w_rx_shift_d = 7'd0;
                    w_tx_shift_d = 8'h00;
                end else begin
                    // CPHA=0: bit 7 is already on the line from the load, so
                    // the shift edge that ends a byte (count wrapped to 0)
                    // must not advance.
                    if (w_shift && (c_CPHA || (r_bit_cnt_q != 3'd0))) begin
                        w_miso_d     = r_tx_shift_q[7];
                        w_tx_shift_d = {r_tx_shift_q[6:0], 1'b0};
                    end
                    if (w_sample) begin
                        w_rx_shift_d = {r_rx_shift_q[5:0], r_mosi_sync_q};
                        w_bit_cnt_d  = r_bit_cnt_q + 3'd1;
                    end
                    if (w_byte_done) begin
                        w_rx_byte_d = {r_rx_shift_q, r_mosi_sync_q};
                        w_rx_dv_d   = 1'b1;
                        if (c_CPHA) begin
                            w_tx_shift_d = w_load_val;
                        end else begin
                            w_miso_d     = w_load_val[7];
                            w_tx_shift_d = {w_load_val[6:0], 1'b0};
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_sck_meta_q  <= c_CPOL;
            r_sck_sync_q  <= c_CPOL;
            r_sck_prev_q  <= c_CPOL;
            r_cs_meta_q   <= 1'b1;
            r_cs_sync_q   <= 1'b1;
            r_cs_prev_q   <= 1'b1;
            r_mosi_meta_q <= 1'b0;
            r_mosi_sync_q <= 1'b0;
            r_flush_cnt_q <= 2'd0;
            r_cs_armed_q  <= 1'b0;
            r_state_q     <= ST_IDLE;
            r_bit_cnt_q   <= 3'd0;
            r_rx_shift_q  <= 7'd0;
            r_rx_byte_q   <= 8'h00;
            r_rx_dv_q     <= 1'b0;
            r_tx_hold_q   <= 8'h00;
            r_tx_ready_q  <= 1'b1;
            r_tx_shift_q  <= 8'h00;
            r_miso_q      <= 1'b0;
            r_miso_en_q   <= 1'b0;
        end else begin
            r_sck_meta_q  <= i_SPI_Clk;
            r_sck_sync_q  <= r_sck_meta_q;
            r_sck_prev_q  <= r_sck_sync_q;
            r_cs_meta_q   <= i_SPI_CS_n;
            r_cs_sync_q   <= r_cs_meta_q;
            r_cs_prev_q   <= r_cs_sync_q;
            r_mosi_meta_q <= i_SPI_MOSI;
            r_mosi_sync_q <= r_mosi_meta_q;
            r_flush_cnt_q <= w_flush_cnt_d;
            r_cs_armed_q  <= w_cs_armed_d;
            r_state_q     <= w_state_d;
            r_bit_cnt_q   <= w_bit_cnt_d;
            r_rx_shift_q  <= w_rx_shift_d;
            r_rx_byte_q   <= w_rx_byte_d;
            r_rx_dv_q     <= w_rx_dv_d;
            r_tx_hold_q   <= w_tx_hold_d;
            r_tx_ready_q  <= w_tx_ready_d;
            r_tx_shift_q  <= w_tx_shift_d;
            r_miso_q      <= w_miso_d;
            r_miso_en_q   <= w_miso_en_d;
        end
    end

    assign o_TX_Ready    = r_tx_ready_q;
    assign o_RX_DV       = r_rx_dv_q;
    assign o_RX_Byte     = r_rx_byte_q;
    assign o_SPI_MISO    = r_miso_q;
    assign o_SPI_MISO_En = r_miso_en_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave
// Description : Self-checking bench for spi_slave. One instance per SPI mode
//               shares a single master waveform (SCK polarity per instance).
//               Expected MISO/RX data come from a byte-level model of the
//               holding register and the master's own MOSI bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    logic       r_clk = 1'b0;
    logic       r_rst = 1'b1;
    logic [7:0] r_tx_byte = 8'h00;
    logic       r_tx_dv = 1'b0;
    logic       r_cs_n = 1'b1;
    logic       r_mosi = 1'b0;
    logic       r_sck_phase = 1'b0;   // 0 = idle level, 1 = active level

    wire  [3:0] w_tx_ready;
    wire  [3:0] w_rx_dv;
    wire  [7:0] w_rx_byte [4];
    wire  [3:0] w_miso;
    wire  [3:0] w_miso_en;

    always #5 r_clk = ~r_clk;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        spi_slave #(.SPI_MODE(m)) u_dut (
            .i_Clk         (r_clk),
            .i_Rst         (r_rst),
            .i_TX_Byte     (r_tx_byte),
            .i_TX_DV       (r_tx_dv),
            .o_TX_Ready    (w_tx_ready[m]),
            .o_RX_DV       (w_rx_dv[m]),
            .o_RX_Byte     (w_rx_byte[m]),
            .i_SPI_Clk     (r_sck_phase ^ (m >= 2)),
            .i_SPI_CS_n    (r_cs_n),
            .i_SPI_MOSI    (r_mosi),
            .o_SPI_MISO    (w_miso[m]),
            .o_SPI_MISO_En (w_miso_en[m])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;
    int hp       = 4;

    // Reference model: one-byte holding register
    logic [7:0] m_hold = 8'h00;
    bit         m_full = 1'b0;

    // RX monitor log
    int         rx_cnt [4];
    logic [7:0] rx_log [4][64];

    logic [7:0] mosi_buf   [4];
    bit         refill_en  [4];
    logic [7:0] refill_val [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge r_clk) begin
        for (int m = 0; m < 4; m++) begin
            if (w_rx_dv[m] === 1'b1) begin
                rx_log[m][rx_cnt[m] % 64] = w_rx_byte[m];
                rx_cnt[m] = rx_cnt[m] + 1;
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge r_clk);
    endtask

    task automatic model_take(output logic [7:0] v);
        v      = m_full ? m_hold : 8'h00;
        m_full = 1'b0;
    endtask

    task automatic write_tx(input logic [7:0] b);
        r_tx_byte = b;
        r_tx_dv   = 1'b1;
        wait_clks(1);
        r_tx_dv   = 1'b0;
        if (!m_full) begin
            m_hold = b;
            m_full = 1'b1;
        end
        for (int m = 0; m < 4; m++)
            check_eq($sformatf("tx_ready_after_write m%0d", m), w_tx_ready[m], !m_full);
    endtask

    // One bit: MOSI valid across both edges; MISO sampled just before the
    // edge on which the master samples in each mode.
    task automatic clock_bit(input logic mb, output logic [3:0] mi);
        r_mosi = mb;
        wait_clks(hp);
        mi[0] = w_miso[0];
        mi[2] = w_miso[2];
        r_sck_phase = 1'b1;
        wait_clks(hp);
        mi[1] = w_miso[1];
        mi[3] = w_miso[3];
        r_sck_phase = 1'b0;
        wait_clks(2);
    endtask

    task automatic clear_bufs();
        for (int k = 0; k < 4; k++) begin
            refill_en[k]  = 1'b0;
            refill_val[k] = 8'h00;
        end
    endtask

    task automatic xfer(input int nb, input int abort_bits);
        int         base [4];
        logic [7:0] exp  [4];
        logic [7:0] got  [4];
        logic [3:0] mi;
        int         done_bytes;
        int         nbits;
        done_bytes = 0;
        nbits      = 0;
        for (int m = 0; m < 4; m++) base[m] = rx_cnt[m];
        r_cs_n = 1'b0;
        wait_clks(4);
        for (int k = 0; k < nb; k++) begin
            model_take(exp[k]);
            for (int m = 0; m < 4; m++) got[m] = 8'h00;
            for (int i = 0; i < 8; i++) begin
                if (abort_bits != 0 && nbits == abort_bits) break;
                clock_bit(mosi_buf[k][7-i], mi);
                nbits++;
                for (int m = 0; m < 4; m++) got[m] = {got[m][6:0], mi[m]};
                if (i == 3 && k + 1 < nb && refill_en[k+1]) begin
                    for (int m = 0; m < 4; m++)
                        check_eq($sformatf("tx_ready_mid m%0d", m), w_tx_ready[m], !m_full);
                    write_tx(refill_val[k+1]);
                end
            end
            if (abort_bits != 0 && nbits == abort_bits) break;
            done_bytes++;
            for (int m = 0; m < 4; m++) begin
                check_eq($sformatf("miso_byte m%0d b%0d", m, k), got[m], exp[k]);
                check_eq($sformatf("miso_en_active m%0d", m), w_miso_en[m], 1);
            end
        end
        wait_clks(hp);
        r_cs_n = 1'b1;
        wait_clks(8);
        for (int m = 0; m < 4; m++) begin
            check_eq($sformatf("miso_en_idle m%0d", m), w_miso_en[m], 0);
            check_eq($sformatf("miso_idle m%0d", m), w_miso[m], 0);
            check_eq($sformatf("rx_dv_count m%0d", m), rx_cnt[m] - base[m], done_bytes);
            for (int j = 0; j < done_bytes; j++)
                check_eq($sformatf("rx_byte m%0d b%0d", m, j),
                         rx_log[m][(base[m] + j) % 64], mosi_buf[j]);
            if (done_bytes > 0)
                check_eq($sformatf("rx_hold m%0d", m), w_rx_byte[m], mosi_buf[done_bytes-1]);
        end
    endtask

    task automatic reset_mid_transfer();
        int         base [4];
        logic [3:0] mi;
        r_cs_n = 1'b0;
        wait_clks(4);
        for (int i = 0; i < 3; i++) clock_bit(1'b1, mi);
        r_rst = 1'b1;
        wait_clks(2);
        r_rst  = 1'b0;
        m_full = 1'b0;
        for (int m = 0; m < 4; m++) base[m] = rx_cnt[m];
        for (int i = 0; i < 8; i++) clock_bit(1'($urandom_range(0, 1)), mi);
        for (int m = 0; m < 4; m++) begin
            check_eq($sformatf("rst_mid_en m%0d", m), w_miso_en[m], 0);
            check_eq($sformatf("rst_mid_rxdv m%0d", m), rx_cnt[m] - base[m], 0);
            check_eq($sformatf("rst_mid_ready m%0d", m), w_tx_ready[m], 1);
        end
        wait_clks(hp);
        r_cs_n = 1'b1;
        wait_clks(8);
    endtask

    initial begin
        int nb;
        int ab;
        for (int m = 0; m < 4; m++) rx_cnt[m] = 0;
        clear_bufs();
        r_rst = 1'b1;
        wait_clks(3);
        for (int m = 0; m < 4; m++) begin
            check_eq($sformatf("reset_tx_ready m%0d", m), w_tx_ready[m], 1);
            check_eq($sformatf("reset_rx_dv m%0d", m), w_rx_dv[m], 0);
            check_eq($sformatf("reset_rx_byte m%0d", m), w_rx_byte[m], 0);
            check_eq($sformatf("reset_miso m%0d", m), w_miso[m], 0);
            check_eq($sformatf("reset_miso_en m%0d", m), w_miso_en[m], 0);
        end
        r_rst = 1'b0;
        wait_clks(6);

        // Basic exchange in every mode
        hp = 4;
        write_tx(8'hA5);
        mosi_buf[0] = 8'h3C;
        xfer(1, 0);

        // Back-to-back with refill once ready rises
        write_tx(8'h11);
        mosi_buf[0] = 8'hF0;
        mosi_buf[1] = 8'h0F;
        refill_en[1]  = 1'b1;
        refill_val[1] = 8'h22;
        xfer(2, 0);
        clear_bufs();

        // Underrun
        mosi_buf[0] = 8'h81;
        xfer(1, 0);

        // Abort after 5 bits, then a clean byte
        mosi_buf[0] = 8'hC7;
        xfer(1, 5);
        mosi_buf[0] = 8'h5A;
        xfer(1, 0);

        // Second write while full is ignored
        write_tx(8'h5C);
        write_tx(8'hEE);
        mosi_buf[0] = 8'h99;
        xfer(1, 0);

        // Reset in the middle of a transfer, then recovery
        hp = 5;
        write_tx(8'h3A);
        reset_mid_transfer();
        write_tx(8'hC3);
        mosi_buf[0] = 8'h7E;
        xfer(1, 0);

        // Randomized transfers
        for (int it = 0; it < 24; it++) begin
            hp = $urandom_range(4, 7);
            nb = $urandom_range(1, 3);
            ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
            if (ab != 0) nb = 1;
            if ($urandom_range(0, 1) == 1) write_tx(8'($urandom));
            for (int k = 0; k < 4; k++) begin
                mosi_buf[k]   = 8'($urandom);
                refill_en[k]  = 1'($urandom_range(0, 1));
                refill_val[k] = 8'($urandom);
            end
            xfer(nb, ab);
            wait_clks($urandom_range(2, 10));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: SPI_MODE, default 0, SPI mode 0-3; CPOL = mode 2 or 3, CPHA = mode 1 or 3.
REQ-002 i_Clk  in  1  system clock; single clock domain, all logic on rising edge.
REQ-003 i_Rst  in  1  reset; synchronous, active-high.
REQ-004 i_TX_Byte  in  8  byte to return to master on MISO.
REQ-005 i_TX_DV  in  1  one-cycle strobe; i_TX_Byte valid.
REQ-006 o_TX_Ready  out  1  high when the TX holding register is empty.
REQ-007 o_RX_DV  out  1  one-cycle pulse; o_RX_Byte holds a new complete byte.
REQ-008 o_RX_Byte  out  8  last complete byte received on MOSI.
REQ-009 i_SPI_Clk  in  1  SPI clock from master; asynchronous to i_Clk.
REQ-010 i_SPI_CS_n  in  1  chip select, active-low; asynchronous.
REQ-011 i_SPI_MOSI  in  1  serial data from master; asynchronous.
REQ-012 o_SPI_MISO  out  1  serial data to master, MSB first.
REQ-013 o_SPI_MISO_En  out  1  MISO output enable for the top-level tristate buffer.

Function
REQ-014 i_SPI_Clk, i_SPI_CS_n and i_SPI_MOSI SHALL each pass through a 2-flop synchronizer; all protocol decisions use the synchronized copies.
REQ-015 Edge detect on synchronized SCK: leading edge = transition away from CPOL; trailing edge = transition back to CPOL; each detected edge is a 1-cycle internal strobe.
REQ-016 Sample edge = leading if CPHA=0, else trailing; shift edge = the opposite edge.
REQ-017 FSM states: IDLE and ACTIVE; IDLE->ACTIVE on synchronized CS_n high->low; ACTIVE->IDLE on synchronized CS_n low->high; SCK edges in IDLE are ignored.
REQ-018 o_SPI_MISO_En SHALL be 1 exactly while in ACTIVE; o_SPI_MISO SHALL be 0 in IDLE.
REQ-019 TX handshake: i_TX_DV with o_TX_Ready=1 writes i_TX_Byte into the holding register; o_TX_Ready goes 0 the next cycle; i_TX_DV with o_TX_Ready=0 is ignored and the holding value is unchanged.
REQ-020 Byte load: the TX shift register loads from the holding register on IDLE->ACTIVE entry and after every 8th sample edge; the holding register is emptied and o_TX_Ready returns to 1 the next cycle.
REQ-021 Underrun: if the holding register is empty at a byte load, the shift register loads 0x00.
REQ-022 Same-cycle i_TX_DV and byte load with holding empty: the shift register loads 0x00; i_TX_Byte is captured into holding for the following byte.
REQ-023 CPHA=0: bit 7 of a loaded byte drives o_SPI_MISO in the cycle after the load; bits 6..0 are driven on successive shift edges.
REQ-024 CPHA=1: bits 7..0 are driven on successive shift edges, starting with the first leading edge of the byte.
REQ-025 RX: on each sample edge the synchronized MOSI shifts in MSB-first; a 3-bit counter wraps 7->0 per byte.
REQ-026 On the 8th sample edge, o_RX_Byte updates and o_RX_DV pulses high for exactly one cycle, both in the cycle after the edge strobe; o_RX_Byte holds until the next complete byte.
REQ-027 CS_n deassert mid-byte: partial RX bits are discarded with no o_RX_DV; bit counters reset; the TX shift content is discarded; the holding register is retained.
REQ-028 Back-to-back bytes with CS_n held low SHALL run without gaps; each byte produces exactly one o_RX_DV.
REQ-029 Supported timing: each SCK half-period and the CS_n setup/hold to the first/last SCK edge SHALL each be at least 4 i_Clk cycles; behaviour outside this range is undefined.

Reset
REQ-030 With i_Rst=1 at a rising i_Clk edge: FSM=IDLE, o_TX_Ready=1, o_RX_DV=0, o_RX_Byte=0x00, o_SPI_MISO=0, o_SPI_MISO_En=0, holding register empty, bit counters cleared.
REQ-031 Synchronizer reset values: SCK=CPOL, CS_n=1, MOSI=0; no edge is detected in the first cycle after reset.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no o_RX_DV; the block resumes only at the next CS_n falling edge after reset release.

Verification
REQ-033 Mode 0, half-bit 4 clks: load 0xA5, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; o_RX_Byte=0x3C with a single o_RX_DV pulse.
REQ-034 Modes 1, 2, 3 each: same exchange -> identical data on both lines, sampled on the mode's correct edges.
REQ-035 Back-to-back: load 0x11, then 0x22 once o_TX_Ready rises; master sends 0xF0,0x0F under one CS -> MISO 0x11,0x22; two o_RX_DV pulses carrying 0xF0 then 0x0F.
REQ-036 Underrun: no load, master sends 0x81 -> MISO 0x00; o_RX_Byte=0x81.
REQ-037 Abort: CS_n rises after 5 bits -> no o_RX_DV; next full byte 0x5A is received correctly; o_SPI_MISO_En=0 while CS_n is high.
REQ-038 i_TX_DV while o_TX_Ready=0 -> ignored; byte sent equals the first accepted value.
